// File: rtl/key_expansion.sv
// AES-128 key expansion: iterative, one round key per clock edge.
// FSM IDLE -> EXPAND (10 edges) -> DONE; out holds all 11 round keys, RK0 in the top slot.
// Optional build macro KEY_EXPANSION_CLEAR_EN: the capture edge also zeroes RK1..RK10.
module key_expansion (
  input  logic            clk,
  input  logic            rst,
  input  logic [127:0]    key,
  input  logic            start,
  output logic [1407:0]   out,
  output logic            finish
);

  typedef enum logic [1:0] {StIdle, StExpand, StDone} state_e;

  // FIPS-197 forward S-box; entry 0 sits in the most significant byte.
  localparam logic [2047:0] SboxTbl = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry a lives at byte index 255-a, i.e. ~a for an 8-bit a.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    return SboxTbl[{~a, 3'b000} +: 8];
  endfunction

  state_e          state_q, state_d;
  logic [3:0]      counter_q, counter_d;
  logic [7:0]      rcon_q, rcon_d;
  logic [1407:0]   out_q, out_d;
  logic            finish_q, finish_d;
  logic            start_prev_q, start_prev_d;

  logic            capture;
  logic [127:0]    prev_rk, next_rk;
  logic [31:0]     w0, w1, w2, w3, rot, sub, n0, n1, n2, n3;

  // Level start in IDLE; only a rising start edge restarts from DONE.
  assign capture = ((state_q == StIdle) && start) ||
                   ((state_q == StDone) && start && !start_prev_q);

  // Round function: previous round key selected by counter, next key from FIPS-197 word rule.
  always_comb begin
    prev_rk = '0;
    for (int i = 0; i < 10; i++) begin
      if (counter_q == 4'(i + 1)) prev_rk = out_q[1407 - 128*i -: 128];
    end
    {w0, w1, w2, w3} = prev_rk;
    rot = {w3[23:0], w3[31:24]};
    sub = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
    n0 = w0 ^ sub ^ {rcon_q, 24'h0};
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    next_rk = {n0, n1, n2, n3};
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      counter_q    <= 4'd0;
      rcon_q       <= 8'h01;
      out_q        <= '0;
      finish_q     <= 1'b0;
      start_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      counter_q    <= counter_d;
      rcon_q       <= rcon_d;
      out_q        <= out_d;
      finish_q     <= finish_d;
      start_prev_q <= start_prev_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (capture) state_d = StExpand;
      StExpand: if (counter_q == 4'd10) state_d = StDone;
      StDone:   if (capture) state_d = StExpand;
      default:  state_d = StIdle;
    endcase
  end

  // Datapath / registered-output next values.
  always_comb begin
    counter_d    = counter_q;
    rcon_d       = rcon_q;
    out_d        = out_q;
    finish_d     = finish_q;
    start_prev_d = start;
    if (capture) begin
      out_d[1407:1280] = key;
`ifdef KEY_EXPANSION_CLEAR_EN
      out_d[1279:0]    = '0;
`else
      out_d[1279:0]    = out_q[1279:0];
`endif
      rcon_d    = 8'h01;
      counter_d = 4'd1;
      finish_d  = 1'b0;
    end else if (state_q == StExpand) begin
      for (int i = 1; i <= 10; i++) begin
        if (counter_q == 4'(i)) out_d[1407 - 128*i -: 128] = next_rk;
      end
      rcon_d    = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
      counter_d = counter_q + 4'd1;
      if (counter_q == 4'd10) finish_d = 1'b1;
    end
  end

  assign out    = out_q;
  assign finish = finish_q;

endmodule

// File: tb/tb_key_expansion.sv
// Directed bench for key_expansion using FIPS-197 and all-zero key vectors.
module tb_key_expansion;

  logic          clk;
  logic          rst;
  logic [127:0]  key;
  logic          start;
  logic [1407:0] out;
  logic          finish;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [127:0] FipsKey  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FipsRk1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FipsRk2  = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] FipsRk10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZeroRk1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZeroRk10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  key_expansion dut (
    .clk    (clk),
    .rst    (rst),
    .key    (key),
    .start  (start),
    .out    (out),
    .finish (finish)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] rk(input int i);
    return out[1407 - 128*i -: 128];
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Counts edges after the capture edge until finish is seen (bounded); optionally toggles
  // key and start after every edge while expansion is in progress.
  task automatic wait_finish(input bit tog, output int n);
    n = 0;
    while (n < 20) begin
      @(posedge clk);
      n++;
      #1;
      if (finish) break;
      if (tog) begin
        key   = ~key;
        start = ~start;
      end
    end
  endtask

  int n;

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    key   = '0;
    #12;
    check("reset_rk0", rk(0), '0);
    check("reset_rk10", rk(10), '0);
    check("reset_finish", 128'(finish), 128'd0);

    // Level start on the first edge after reset release, start held high.
    @(negedge clk);
    rst   = 1'b0;
    key   = FipsKey;
    start = 1'b1;
    @(posedge clk); #1;
    check("fips_rk0", rk(0), FipsKey);
    check("fips_finish_low", 128'(finish), 128'd0);
    wait_finish(1'b0, n);
    check("fips_latency", 128'(n), 128'd10);
    check("fips_rk1", rk(1), FipsRk1);
    check("fips_rk2", rk(2), FipsRk2);
    check("fips_rk10", rk(10), FipsRk10);

    // Held start in DONE must not restart.
    repeat (20) @(posedge clk);
    #1;
    check("hold_finish", 128'(finish), 128'd1);
    check("hold_rk0", rk(0), FipsKey);
    check("hold_rk10", rk(10), FipsRk10);

    // Rising start edge restarts with a new key.
    start = 1'b0;
    @(posedge clk); #1;
    key   = '0;
    start = 1'b1;
    @(posedge clk); #1;
    check("restart_finish_low", 128'(finish), 128'd0);
    check("restart_rk0", rk(0), '0);
`ifdef KEY_EXPANSION_CLEAR_EN
    check("restart_rk1_cleared", rk(1), '0);
    check("restart_rk10_cleared", rk(10), '0);
`else
    check("restart_rk1_kept", rk(1), FipsRk1);
    check("restart_rk10_kept", rk(10), FipsRk10);
`endif
    wait_finish(1'b0, n);
    check("zero_latency", 128'(n), 128'd10);
    check("zero_rk1", rk(1), ZeroRk1);
    check("zero_rk10", rk(10), ZeroRk10);

    // Asynchronous reset at counter==5.
    start = 1'b0;
    @(posedge clk); #1;
    key   = FipsKey;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_rk0", rk(0), '0);
    check("async_rk10", rk(10), '0);
    check("async_finish", 128'(finish), 128'd0);
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_finish(1'b0, n);
    check("rerun_latency", 128'(n), 128'd10);
    check("rerun_rk1", rk(1), FipsRk1);
    check("rerun_rk10", rk(10), FipsRk10);

    // All-zero key with a one-cycle start pulse from IDLE.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    key   = '0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("pulse_rk0", rk(0), '0);
    wait_finish(1'b0, n);
    check("pulse_latency", 128'(n), 128'd10);
    check("pulse_rk1", rk(1), ZeroRk1);
    check("pulse_rk10", rk(10), ZeroRk10);

    // Key and start toggled every cycle during EXPAND.
    key   = FipsKey;
    start = 1'b1;
    @(posedge clk); #1;
    wait_finish(1'b1, n);
    start = 1'b0;
    check("toggle_latency", 128'(n), 128'd10);
    check("toggle_rk0", rk(0), FipsKey);
    check("toggle_rk1", rk(1), FipsRk1);
    check("toggle_rk10", rk(10), FipsRk10);
    repeat (3) @(posedge clk);
    #1;
    check("toggle_hold_finish", 128'(finish), 128'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
